hazard_ctrl: RTL
================

# hazard_ctrl

Central stall/flush sequencer for the 16-bit five-stage pipeline. Watches decode operands, the EX-stage load and branch outcome, and the data-memory handshake. Drives per-register stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Holds an FSM for multi-cycle data-memory waits, a wait timeout, and a sticky halt.

## Interface
- `MEM_TIMEOUT`, 16: maximum consecutive cycles spent in MEM_WAIT before an error; legal range 1..255.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 3: source register numbers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction actually reads rs1/rs2.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_write_reg` in 3: destination register of the instruction in EX.
- `ex_branch_taken` in 1: branch/jump resolved taken in EX this cycle.
- `mem_req` in 1: MEM stage holds a load or store this cycle.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `halt_req` in 1: HALT instruction has reached WB.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` out 1: hold the register.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1: load a bubble (all zeros).
- `mem_error` out 1: sticky; set when a data-memory access times out.
- `halted` out 1: the FSM is in HALT.

## Operation
- States: RUN, MEM_WAIT, HALT. Reset enters RUN with the wait counter at 0 and `mem_error` at 0.
- Outputs are combinational from the current state plus inputs. Every stall/flush output defaults to 0.
- **RUN, first priority: memory wait.** Condition: `mem_req` = 1 and `dmem_ready` = 0.
  - Assert `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_flush`.
  - Next state is MEM_WAIT; the counter loads 1.
  - A branch or load-use in the same cycle is ignored. Both are re-evaluated after the wait because the EX and ID contents are held.
- **RUN, second priority: taken branch.** Condition: `ex_branch_taken` = 1.
  - Assert `if_id_flush` and `id_ex_flush`; no stalls. State stays RUN.
- **RUN, third priority: load-use.** Condition: `ex_mem_read` = 1 and (`id_uses_rs1` and `id_rs1` == `ex_write_reg`, or `id_uses_rs2` and `id_rs2` == `ex_write_reg`).
  - Assert `pc_stall`, `if_id_stall` and `id_ex_flush`. This is a one-cycle bubble.
  - Register r0 is not special-cased: a match on 0 still stalls.
- **RUN, halt request.** Condition: `halt_req` = 1 with no memory wait.
  - Next state is HALT. The current cycle's outputs follow the normal priorities.
- **MEM_WAIT**
  - Hold the same five outputs as on entry (four stalls plus `mem_wb_flush`).
  - If `dmem_ready` = 1: release everything. All outputs are 0 this cycle, so MEM/WB captures the access result. Next state is RUN; the counter clears.
  - Else if counter == `MEM_TIMEOUT`: set `mem_error`. Next state is HALT.
  - Else: increment the counter.
- **HALT**
  - Assert `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_flush` permanently. Only `rst_n` leaves HALT.
- `mem_error` clears only on reset.
- The counter width is 8 bits. It never wraps because the timeout check precedes the increment.

## Timing
- Reset values: all stall/flush outputs 0, `mem_error` 0, `halted` 0.
- A reset asserted mid-wait or in HALT forces RUN asynchronously, and all outputs drop immediately.
- Latency: stall and flush responses are zero-cycle, asserted in the same cycle as the triggering input.
- Load-use costs exactly 1 cycle. A taken branch costs 2 bubbles.
- A memory access with N wait cycles gives N stall cycles, where N is the number of cycles `dmem_ready` is 0.
- Timeout: with `dmem_ready` held at 0, `mem_error` rises on the edge that ends the (`MEM_TIMEOUT` + 1)-th stalled cycle.
- `halted` is registered. It rises the cycle after the HALT transition.

## Configuration
- `HAZARD_STATS_EN` defined: adds two outputs.
  - `stall_cycles` out 16: counts cycles with `pc_stall` = 1.
  - `flush_events` out 16: counts cycles with `if_id_flush` = 1.
  - Both saturate at 0xFFFF and reset to 0.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- **Load-use on rs2.** Stimulus: `ex_mem_read` = 1, `ex_write_reg` = 3, `id_rs2` = 3, `id_uses_rs2` = 1. Required response: `pc_stall`, `if_id_stall` and `id_ex_flush` are 1 for one cycle. With `id_uses_rs2` = 0 all outputs are 0.
- **Branch plus load-use in the same cycle.** Required response: only `if_id_flush` and `id_ex_flush` are asserted; no stall.
- **Memory wait.** Stimulus: `mem_req` = 1, `dmem_ready` low for 3 cycles, then high. Required response: 3 cycles of four stalls plus `mem_wb_flush`, then a cycle with all outputs 0, and the state returns to RUN.
- **Timeout.** Stimulus: `MEM_TIMEOUT` = 4, `dmem_ready` held at 0. Required response: `mem_error` = 1 after cycle 5. `halted` = 1 one cycle later, with stalls held for 10 further cycles. Asserting `rst_n` = 0 clears everything asynchronously.
- **Halt.** Stimulus: pulse `halt_req` during a load-use. Required response: the load-use bubble is issued that cycle, then the FSM enters HALT permanently.
- **HAZARD_STATS_EN.** Stimulus: 2 load-use stalls plus 1 branch. Required response: `stall_cycles` = 2 and `flush_events` = 1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// The HAZARD_STATS_EN macro adds the two statistics counters to the bundle.
interface hazard_ctrl_if;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_mem_read;
  logic [2:0]  ex_write_reg;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        dmem_ready;
  logic        halt_req;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mem_wb_flush;
  logic        mem_error;
  logic        halted;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_write_reg,
           ex_branch_taken, mem_req, dmem_ready, halt_req,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
`ifdef HAZARD_STATS_EN
           stall_cycles, flush_events,
`endif
           mem_error, halted
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_write_reg,
           ex_branch_taken, mem_req, dmem_ready, halt_req,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
`ifdef HAZARD_STATS_EN
           stall_cycles, flush_events,
`endif
           mem_error, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, taken branch, data-memory wait
// with timeout, and sticky halt. Define HAZARD_STATS_EN to add stall/flush event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
  logic       r_mem_error, w_mem_error_nxt;
  logic       r_halted;

  logic w_mem_wait, w_load_use;
  logic w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
  logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush;

  assign w_mem_wait = hz.mem_req & ~hz.dmem_ready;
  // r0 is deliberately not excluded: a match on register 0 still stalls.
  assign w_load_use = hz.ex_mem_read &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_write_reg)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_write_reg)));

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_mem_error_nxt = r_mem_error;
    w_pc_stall      = 1'b0;
    w_if_id_stall   = 1'b0;
    w_id_ex_stall   = 1'b0;
    w_ex_mem_stall  = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_flush  = 1'b0;
    w_mem_wb_flush  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_wait) begin
          // Branch and load-use are re-evaluated after the wait since EX and ID are held.
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          w_mem_wb_flush = 1'b1;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end else begin
          if (hz.ex_branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_flush = 1'b1;
          end
          if (hz.halt_req) w_state_nxt = HALT;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          // All controls released so MEM/WB captures the completed access.
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          w_mem_wb_flush = 1'b1;
          if (r_wait_cnt == TIMEOUT_C) begin
            w_mem_error_nxt = 1'b1;
            w_state_nxt     = HALT;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
      end
      HALT: begin
        w_pc_stall     = 1'b1;
        w_if_id_stall  = 1'b1;
        w_id_ex_stall  = 1'b1;
        w_ex_mem_stall = 1'b1;
        w_mem_wb_flush = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_mem_error <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_mem_error <= w_mem_error_nxt;
      r_halted    <= (r_state == HALT);
    end
  end

  assign hz.pc_stall     = w_pc_stall;
  assign hz.if_id_stall  = w_if_id_stall;
  assign hz.id_ex_stall  = w_id_ex_stall;
  assign hz.ex_mem_stall = w_ex_mem_stall;
  assign hz.if_id_flush  = w_if_id_flush;
  assign hz.id_ex_flush  = w_id_ex_flush;
  assign hz.ex_mem_flush = w_ex_mem_flush;
  assign hz.mem_wb_flush = w_mem_wb_flush;
  assign hz.mem_error    = r_mem_error;
  assign hz.halted       = r_halted;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles, r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
      r_flush_events <= 16'd0;
    end else begin
      if (w_pc_stall && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_if_id_flush && (r_flush_events != 16'hFFFF))
        r_flush_events <= r_flush_events + 16'd1;
    end
  end

  assign hz.stall_cycles = r_stall_cycles;
  assign hz.flush_events = r_flush_events;
`endif

endmodule
